// File: rtl/usb_receiver_top.sv
// ============================================================================
// Module   : usb_receiver_top
// Purpose  : Full-speed USB receiver. Takes D+/D- at 8x oversampling, does
//            NRZI decode and bit unstuffing, checks SYNC/EOP, and feeds an
//            8-byte first-word-fall-through receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_receiver_top (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus,
    input  logic       d_minus,
    input  logic       r_enable,
    output logic [7:0] r_data,
    output logic       empty,
    output logic       full,
    output logic       rcving,
    output logic       r_error
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SYNC     = 3'd1,
        S_DATA     = 3'd2,
        S_STORE    = 3'd3,
        S_EOP      = 3'd4,
        S_ERR_WAIT = 3'd5
    } state_t;

    localparam logic [7:0] c_SYNC_BYTE = 8'h80;
    localparam logic [2:0] c_SAMPLE_PT = 3'd4;
    localparam logic [2:0] c_STUFF_RUN = 3'd6;
    localparam logic [3:0] c_DEPTH     = 4'd8;

    state_t      r_state, w_state_next;
    logic        r_dp_meta, r_dp_sync, r_dp_last;
    logic        r_dm_meta, r_dm_sync, r_dm_last;
    logic [2:0]  r_timer;
    logic        r_prev_line;
    logic [2:0]  r_ones;
    logic [7:0]  r_shift;
    logic [3:0]  r_bitcnt;
    logic [7:0]  r_mem [0:7];
    logic [2:0]  r_wptr, r_rptr;
    logic [3:0]  r_count;

    logic        w_line_j, w_line_k, w_line_se0;
    logic        w_start, w_sample, w_bit, w_stuff;
    logic [7:0]  w_shift_next;
    logic        w_take_bit, w_clr_cnt, w_set_err, w_clr_err;
    logic        w_push, w_pop;

    // Two-flop synchronizers; idle line (J) is the reset value so no false start edge
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_dp_meta <= 1'b1;
            r_dp_sync <= 1'b1;
            r_dp_last <= 1'b1;
            r_dm_meta <= 1'b0;
            r_dm_sync <= 1'b0;
            r_dm_last <= 1'b0;
        end else begin
            r_dp_meta <= d_plus;
            r_dp_sync <= r_dp_meta;
            r_dp_last <= r_dp_sync;
            r_dm_meta <= d_minus;
            r_dm_sync <= r_dm_meta;
            r_dm_last <= r_dm_sync;
        end
    end

    assign w_line_j     = r_dp_sync & ~r_dm_sync;
    assign w_line_k     = ~r_dp_sync & r_dm_sync;
    assign w_line_se0   = ~r_dp_sync & ~r_dm_sync;
    assign w_start      = (r_state == S_IDLE) && r_dp_last && !r_dm_last && w_line_k;
    assign w_sample     = ((r_state == S_SYNC) || (r_state == S_DATA)) && (r_timer == c_SAMPLE_PT);
    assign w_bit        = (r_dp_sync == r_prev_line);
    assign w_stuff      = (r_ones == c_STUFF_RUN);
    assign w_shift_next = {w_bit, r_shift[7:1]};

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_take_bit   = 1'b0;
        w_clr_cnt    = 1'b0;
        w_set_err    = 1'b0;
        w_clr_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clr_cnt = 1'b1;
                if (w_start) w_state_next = S_SYNC;
            end
            S_SYNC: begin
                if (w_sample && !w_stuff) begin
                    if (w_line_se0) begin
                        w_set_err    = 1'b1;
                        w_state_next = S_EOP;
                    end else begin
                        w_take_bit = 1'b1;
                        if (r_bitcnt == 4'd7) begin
                            w_clr_cnt = 1'b1;
                            if (w_shift_next == c_SYNC_BYTE) begin
                                w_clr_err    = 1'b1;
                                w_state_next = S_DATA;
                            end else begin
                                w_set_err    = 1'b1;
                                w_state_next = S_ERR_WAIT;
                            end
                        end
                    end
                end
            end
            S_DATA: begin
                if (w_sample && !w_stuff) begin
                    if (w_line_se0) begin
                        // A partial byte at end of packet is discarded and flagged
                        w_set_err    = (r_bitcnt != 4'd0);
                        w_clr_cnt    = 1'b1;
                        w_state_next = S_EOP;
                    end else begin
                        w_take_bit = 1'b1;
                        if (r_bitcnt == 4'd7) w_state_next = S_STORE;
                    end
                end
            end
            S_STORE: begin
                w_clr_cnt    = 1'b1;
                w_state_next = S_DATA;
            end
            S_EOP: begin
                if (w_line_j) w_state_next = S_IDLE;
            end
            S_ERR_WAIT: begin
                if (w_line_se0) w_state_next = S_EOP;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bit timer, NRZI history, stuffing run length, byte assembly, error flag
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_timer     <= 3'd0;
            r_prev_line <= 1'b1;
            r_ones      <= 3'd0;
            r_shift     <= 8'h00;
            r_bitcnt    <= 4'd0;
            r_error     <= 1'b0;
        end else begin
            r_timer <= w_start ? 3'd1 : r_timer + 3'd1;
            if (r_state == S_IDLE) begin
                r_prev_line <= 1'b1;
                r_ones      <= 3'd0;
            end else if (w_sample) begin
                r_prev_line <= r_dp_sync;
                if (w_stuff || !w_bit) r_ones <= 3'd0;
                else                   r_ones <= r_ones + 3'd1;
            end
            if (w_take_bit) r_shift <= w_shift_next;
            if (w_clr_cnt)       r_bitcnt <= 4'd0;
            else if (w_take_bit) r_bitcnt <= r_bitcnt + 4'd1;
            if (w_set_err)      r_error <= 1'b1;
            else if (w_clr_err) r_error <= 1'b0;
        end
    end

    assign w_push = (r_state == S_STORE) && (r_count != c_DEPTH);
    assign w_pop  = r_enable && (r_count != 4'd0);

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            for (int i = 0; i < 8; i++) r_mem[i] <= 8'h00;
            r_wptr  <= 3'd0;
            r_rptr  <= 3'd0;
            r_count <= 4'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= r_shift;
                r_wptr        <= r_wptr + 3'd1;
            end
            if (w_pop) r_rptr <= r_rptr + 3'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign r_data = r_mem[r_rptr];
    assign empty  = (r_count == 4'd0);
    assign full   = (r_count == c_DEPTH);
    assign rcving = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_usb_receiver_top.sv
// ============================================================================
// Module   : tb_usb_receiver_top
// Purpose  : Self-checking bench; builds line-level packets from byte lists
//            and compares FIFO contents and status against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_usb_receiver_top;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic       d_plus;
    logic       d_minus;
    logic       r_enable;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic       rcving;
    logic       r_error;

    int         checks   = 0;
    int         failures = 0;
    logic       tx_bits[$];
    logic [7:0] exp_q[$];
    logic       exp_err;

    usb_receiver_top dut (
        .clk      (tb_clk),
        .n_rst    (n_rst),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .r_enable (r_enable),
        .r_data   (r_data),
        .empty    (empty),
        .full     (full),
        .rcving   (rcving),
        .r_error  (r_error)
    );

    always #5 tb_clk = ~tb_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Hold a line state for a whole number of bit times (8 clocks each)
    task automatic drive(input logic dp, input logic dm, input int nbits);
        d_plus  = dp;
        d_minus = dm;
        repeat (nbits * 8) @(negedge tb_clk);
    endtask

    task automatic add_byte(input logic [7:0] b, input bit keep);
        for (int i = 0; i < 8; i++) tx_bits.push_back(b[i]);
        if (keep && exp_q.size() < 8) exp_q.push_back(b);
    endtask

    // Stuff, NRZI-encode and transmit tx_bits, then EOP (SE0 x2, J) plus idle
    task automatic send(input int idle_bits);
        logic lvl;
        int   ones;
        logic lv[$];
        lvl  = 1'b1;
        ones = 0;
        foreach (tx_bits[i]) begin
            if (!tx_bits[i]) lvl = ~lvl;
            lv.push_back(lvl);
            ones = tx_bits[i] ? ones + 1 : 0;
            if (ones == 6) begin
                lvl = ~lvl;
                lv.push_back(lvl);
                ones = 0;
            end
        end
        foreach (lv[i]) begin
            drive(lv[i], ~lv[i], 1);
            if (i == 3) check1("rcving_mid_packet", rcving, 1'b1);
        end
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 1 + idle_bits);
        tx_bits.delete();
    endtask

    task automatic pop_one();
        r_enable = 1'b1;
        @(negedge tb_clk);
        r_enable = 1'b0;
    endtask

    task automatic verify(input string pkt);
        check1({pkt, "/rcving_after"}, rcving, 1'b0);
        check1({pkt, "/r_error"}, r_error, exp_err);
        if (exp_q.size() == 8) check1({pkt, "/full"}, full, 1'b1);
        while (exp_q.size() > 0) begin
            check1({pkt, "/empty_before_pop"}, empty, 1'b0);
            check8({pkt, "/r_data"}, r_data, exp_q.pop_front());
            pop_one();
        end
        check1({pkt, "/empty_after"}, empty, 1'b1);
        check1({pkt, "/full_after"}, full, 1'b0);
    endtask

    initial begin
        int nb;
        n_rst    = 1'b1;
        d_plus   = 1'b1;
        d_minus  = 1'b0;
        r_enable = 1'b0;
        exp_err  = 1'b0;
        repeat (3) @(negedge tb_clk);
        check8("reset/r_data", r_data, 8'h00);
        check1("reset/empty", empty, 1'b1);
        check1("reset/full", full, 1'b0);
        check1("reset/rcving", rcving, 1'b0);
        check1("reset/r_error", r_error, 1'b0);
        n_rst = 1'b0;
        drive(1'b1, 1'b0, 4);
        check1("idle/rcving", rcving, 1'b0);
        pop_one();
        check8("empty_read/r_data", r_data, 8'h00);
        check1("empty_read/empty", empty, 1'b1);

        add_byte(8'h80, 0); add_byte(8'h55, 1);
        send(2); verify("p55");

        add_byte(8'h80, 0); add_byte(8'h00, 1); add_byte(8'h40, 1); add_byte(8'h61, 1);
        send(2); verify("p3bytes");

        add_byte(8'h00, 0); add_byte(8'h40, 0);
        exp_err = 1'b1;
        send(2); verify("bad_sync");

        add_byte(8'h80, 0);
        for (int i = 0; i < 5; i++) tx_bits.push_back(1'b0);
        exp_err = 1'b1;
        send(2); verify("partial_byte");

        add_byte(8'h80, 0);
        exp_err = 1'b0;
        send(2); verify("sync_only");

        add_byte(8'h80, 0); send(0);
        add_byte(8'h80, 0); add_byte(8'h81, 1);
        send(2); verify("back_to_back");

        add_byte(8'h80, 0); add_byte(8'h7E, 1); add_byte(8'hFF, 1); add_byte(8'h3F, 1);
        send(2); verify("stuffing");

        add_byte(8'h80, 0);
        for (int i = 0; i < 9; i++) add_byte(8'($urandom), 1);
        send(2); verify("overflow");

        for (int p = 0; p < 3; p++) begin
            add_byte(8'h80, 0);
            nb = int'($urandom_range(1, 4));
            for (int i = 0; i < nb; i++) add_byte(8'($urandom), 1);
            send(2); verify("random");
        end

        // Leave a byte and an error pending, then reset in the middle of a packet
        add_byte(8'h80, 0); add_byte(8'hA5, 0);
        for (int i = 0; i < 3; i++) tx_bits.push_back(1'b0);
        send(2);
        check1("pre_reset/r_error", r_error, 1'b1);
        check1("pre_reset/empty", empty, 1'b0);
        drive(1'b0, 1'b1, 1); drive(1'b1, 1'b0, 1); drive(1'b0, 1'b1, 1);
        check1("pre_reset/rcving", rcving, 1'b1);
        n_rst   = 1'b1;
        d_plus  = 1'b1;
        d_minus = 1'b0;
        @(negedge tb_clk);
        check1("mid_reset/rcving", rcving, 1'b0);
        check1("mid_reset/empty", empty, 1'b1);
        check1("mid_reset/r_error", r_error, 1'b0);
        check8("mid_reset/r_data", r_data, 8'h00);
        n_rst = 1'b0;
        drive(1'b1, 1'b0, 4);
        exp_err = 1'b0;
        add_byte(8'h80, 0); add_byte(8'hC3, 1);
        send(2); verify("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
